// File: rtl/boot_controller.sv
// boot_controller: byte-stream loader that fills the instruction ROM, verifies an XOR
// checksum and then releases the CPU from reset.
module boot_controller #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rom_we,
    output logic [14:0] rom_addr,
    output logic [15:0] rom_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, RUN, ERR} state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, idx_q, idx_d;
    logic [7:0]    hi_q, hi_d, sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          acc, in_load, we_d, ready_d;
    logic [14:0]   addr_d;
    logic [15:0]   wdata_d;

    assign acc = rx_valid & rx_ready;
    assign in_load = state_q inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        we_d    = 1'b0;
        addr_d  = rom_addr;
        wdata_d = rom_wdata;
        if (acc) begin
            tmo_d = '0;
            case (state_q)
                IDLE:    state_d = rx_data == 8'hA5 ? CNT_HI : rx_data == 8'h52 ? RUN : IDLE;
                CNT_HI:  begin
                    cnt_d[15:8] = rx_data;
                    state_d     = CNT_LO;
                end
                CNT_LO:  begin
                    cnt_d[7:0] = rx_data;
                    state_d    = cnt_d == 16'h0 ? CHK : cnt_d > 16'h8000 ? ERR : DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = rx_data;
                    sum_d   = sum_q ^ rx_data;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[14:0];
                    wdata_d = {hi_q, rx_data};
                    sum_d   = sum_q ^ rx_data;
                    idx_d   = idx_q + 16'd1;
                    state_d = idx_d == cnt_q ? CHK : DATA_HI;
                end
                CHK:     state_d = rx_data == sum_q ? RUN : ERR;
                default: state_d = rx_data == 8'hA5 ? CNT_HI : state_q;
            endcase
        end else if (in_load) begin
            tmo_d   = tmo_q == TMO_MAX ? '0 : tmo_q + 1'b1;
            state_d = tmo_q == TMO_MAX ? ERR : state_q;
        end
        // a fresh load restarts the checksum and word index
        if (state_d == CNT_HI && state_q != CNT_HI) begin
            sum_d = '0;
            idx_d = '0;
        end
        ready_d = !(we_d || (state_d == CHK && state_q != CHK));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            hi_q      <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            rx_ready  <= 1'b1;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            rx_ready  <= ready_d;
            rom_we    <= we_d;
            rom_addr  <= addr_d;
            rom_wdata <= wdata_d;
            cpu_reset <= state_d != RUN;
            busy      <= state_d inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK};
            err       <= state_d == ERR;
        end
    end
endmodule

// File: tb/tb_boot_controller.sv
// tb_boot_controller: directed and randomized load frames checked against a frame-level
// reference (expected writes and pass/fail outcome computed from the frame contents).
module tb_boot_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, rom_we, cpu_reset, busy, err;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;

    int          tests = 0;
    int          fails = 0;
    logic [30:0] got[$];
    logic [30:0] exp_wr[$];
    logic [15:0] words[$];
    logic        prev_we = 1'b0;
    logic [7:0]  junk;
    logic [15:0] cnt;
    logic [7:0]  delta;

    always #5 clk = ~clk;

    boot_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    // every write strobe must be a single-cycle pulse; record what was written
    always @(negedge clk) begin
        if (rom_we) begin
            check("we_pulse", {31'b0, prev_we}, 0);
            got.push_back({rom_addr, rom_wdata});
        end
        prev_we = rom_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", {31'b0, rx_ready}, 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 1);
        check({tag, "_rom_we"}, {31'b0, rom_we}, 0);
        check({tag, "_rom_addr"}, {17'b0, rom_addr}, 0);
        check({tag, "_rom_wdata"}, {16'b0, rom_wdata}, 0);
        check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 1);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_err"}, {31'b0, err}, 0);
    endtask

    task automatic compare_writes();
        check("n_writes", got.size(), exp_wr.size());
        for (int i = 0; i < got.size() && i < exp_wr.size(); i++) check("write", {1'b0, got[i]}, {1'b0, exp_wr[i]});
        got.delete();
        exp_wr.delete();
    endtask

    // one complete frame: header, count, words from 'words', checksum xor'ed with delta
    task automatic load(input logic [15:0] c, input logic [7:0] d);
        logic [7:0] x;
        logic       bad;
        x = 8'h00;
        bad = (c > 16'h8000) || (d != 8'h00);
        send(8'hA5);
        check("busy_start", {31'b0, busy}, 1);
        check("cpu_reset_start", {31'b0, cpu_reset}, 1);
        check("err_start", {31'b0, err}, 0);
        send(c[15:8]);
        send(c[7:0]);
        if (c <= 16'h8000) begin
            for (int i = 0; i < int'(c); i++) begin
                send(words[i][15:8]);
                send(words[i][7:0]);
                x ^= words[i][15:8] ^ words[i][7:0];
                exp_wr.push_back({15'(i), words[i]});
            end
            send(x ^ d);
        end
        check("err_end", {31'b0, err}, {31'b0, bad});
        check("cpu_reset_end", {31'b0, cpu_reset}, {31'b0, bad});
        check("busy_end", {31'b0, busy}, 0);
        compare_writes();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset("por");

        words = '{16'h1234, 16'hABCD};
        load(16'd2, 8'h00);
        load(16'd2, 8'h01);
        words.delete();
        load(16'd0, 8'h00);
        load(16'h8001, 8'h00);

        do_reset();
        send(8'h52);
        check("boot_cpu_reset", {31'b0, cpu_reset}, 0);
        check("boot_busy", {31'b0, busy}, 0);
        send(8'hA5);
        check("reload_cpu_reset", {31'b0, cpu_reset}, 1);
        check("reload_busy", {31'b0, busy}, 1);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        check("reload_run", {31'b0, cpu_reset}, 0);

        do_reset();
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        send(8'h12);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) check("tmo_not_yet", {31'b0, err}, 0);
            if (i == 16) check("tmo_err", {31'b0, err}, 1);
        end
        check("tmo_busy", {31'b0, busy}, 0);
        compare_writes();

        do_reset();
        send(8'hA5);
        send(8'h00);
        send(8'h02);
        send(8'h12);
        do_reset();
        check_reset("midrst");
        send(8'h34);
        repeat (3) @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 0);
        compare_writes();

        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                send(junk);
            end
            words.delete();
            for (int i = 0; i < 6; i++) words.push_back(16'($urandom));
            cnt = ($urandom_range(0, 7) == 0) ? 16'(32'h8001 + $urandom_range(0, 32'h7FFE)) : 16'($urandom_range(0, 5));
            delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            load(cnt, delta);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
